// File: rtl/write_fifo_status_ctrl.sv
// write_fifo_status_ctrl
// Write-path burst scheduler: watches the video-input FIFO fill level and asks
// the AXI write master to drain it, with a full THRESHOLD-beat burst when
// enough data is buffered, or a shorter tail burst to flush the frame residue.
//
// Optional feature macro: WR_TAIL_FLUSH_EN
//   defined   -> tail-burst flush at frame end (trig_tail, WR_TAIL, tail_req)
//   undefined -> tail_req tied low; residue waits for later frames
//
// Ports
//   clock        in   sole clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   permits new requests (in-flight requests always complete)
//   count        in   FIFO word count (9 bits)
//   tail_status  in   last word of the frame is in the FIFO
//   burst_req    out  full-burst request (level)
//   tail_req     out  tail-burst request (level)
//   resp         in   pulse: master accepted the pending request
//   done         in   pulse: accepted burst completed on AXI
//   req_len      out  burst length, stable from request until done
//   busy         out  FSM not idle
//   overflow     out  sticky: FIFO seen at or above FULL_LEN-1
module write_fifo_status_ctrl #(
    parameter int unsigned THRESHOLD = 128,
    parameter int unsigned FULL_LEN  = 256,
    parameter int unsigned LSIZE     = 9
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [8:0]       count,
    input  logic             tail_status,
    output logic             burst_req,
    output logic             tail_req,
    input  logic             resp,
    input  logic             done,
    output logic [LSIZE-1:0] req_len,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned CW = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NEED_WR   = 3'd1,
        WR_TAIL   = 3'd2,
        WAIT_DONE = 3'd3,
        FSH       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             trig_burst_q, trig_burst_d;
    logic             trig_tail_q;
    logic [LSIZE-1:0] req_len_q, req_len_d;
    logic             burst_req_q;
    logic             busy_q;
    logic             overflow_q, overflow_d;

    assign trig_burst_d = enable && (count >= CW'(THRESHOLD));

`ifdef WR_TAIL_FLUSH_EN
    logic          trig_tail_d;
    logic [CW-1:0] cnt_q;
    logic          tail_req_q;

    // Tail only when there is residue that a full burst will not cover.
    assign trig_tail_d = enable && tail_status && (count != '0) && (count < CW'(THRESHOLD));

    // Tail trigger, count snapshot and tail request register
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            trig_tail_q <= 1'b0;
            cnt_q       <= '0;
            tail_req_q  <= 1'b0;
        end else begin
            trig_tail_q <= trig_tail_d;
            cnt_q       <= count;
            tail_req_q  <= (state_d == WR_TAIL);
        end
    end

    assign tail_req = tail_req_q;
`else
    logic unused_tail_status;

    assign unused_tail_status = tail_status;
    assign trig_tail_q        = 1'b0;
    assign tail_req           = 1'b0;
`endif

    // Next state, request length and overflow flag
    always_comb begin
        state_d    = state_q;
        req_len_d  = req_len_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (trig_burst_q) begin
                    state_d = NEED_WR;
                end else if (trig_tail_q) begin
                    state_d = WR_TAIL;
                end
            end
            NEED_WR, WR_TAIL: begin
                if (resp) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d = FSH;
                end
            end
            // One settling cycle so count reflects the drained words.
            FSH:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_d == NEED_WR) && (state_q != NEED_WR)) begin
            req_len_d = LSIZE'(THRESHOLD);
        end
`ifdef WR_TAIL_FLUSH_EN
        else if ((state_d == WR_TAIL) && (state_q != WR_TAIL)) begin
            req_len_d = LSIZE'(cnt_q);
        end
`endif

        // Set wins over clear.
        if (count >= CW'(FULL_LEN - 1)) begin
            overflow_d = 1'b1;
        end else if (!enable) begin
            overflow_d = 1'b0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            trig_burst_q <= 1'b0;
            req_len_q    <= '0;
            burst_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_burst_q <= trig_burst_d;
            req_len_q    <= req_len_d;
            burst_req_q  <= (state_d == NEED_WR);
            busy_q       <= (state_d != IDLE);
            overflow_q   <= overflow_d;
        end
    end

    assign burst_req = burst_req_q;
    assign busy      = busy_q;
    assign req_len   = req_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_write_fifo_status_ctrl.sv
// Bench for write_fifo_status_ctrl: directed scenarios plus a randomized run
// checked against a request/in-flight/cooldown model of the scheduler.
module tb_write_fifo_status_ctrl;

    localparam int unsigned THR  = 128;
    localparam int unsigned FULL = 256;
    localparam int unsigned LS   = 9;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [8:0]    count = '0;
    logic          tail_status = 1'b0;
    logic          resp = 1'b0;
    logic          done = 1'b0;
    logic          burst_req, tail_req, busy, overflow;
    logic [LS-1:0] req_len;

    int n_pass  = 0;
    int n_total = 0;

    // Model: pending request kind (0 none, 1 burst, 2 tail), accepted burst
    // awaiting done, settle cycles remaining, and the one-cycle-late triggers.
    int         m_req;
    bit         m_inflight;
    int         m_cool;
    bit         m_tb, m_tt;
    logic [8:0] m_cnt;
    logic [8:0] m_len;
    bit         m_ovf;

    always #5 clock = ~clock;

    write_fifo_status_ctrl #(.THRESHOLD(THR), .FULL_LEN(FULL), .LSIZE(LS)) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .count(count),
        .tail_status(tail_status), .burst_req(burst_req), .tail_req(tail_req),
        .resp(resp), .done(done), .req_len(req_len), .busy(busy),
        .overflow(overflow)
    );

    task automatic model_reset();
        m_req = 0; m_inflight = 0; m_cool = 0;
        m_tb = 0; m_tt = 0; m_cnt = '0; m_len = '0; m_ovf = 0;
    endtask

    task automatic model_step();
        if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else if (m_inflight) begin
            if (done) begin m_inflight = 0; m_cool = 1; end
        end else if (m_req != 0) begin
            if (resp) begin m_req = 0; m_inflight = 1; end
        end else if (m_tb) begin
            m_req = 1; m_len = 9'(THR);
        end else if (m_tt) begin
            m_req = 2; m_len = m_cnt;
        end
        m_tb = enable && (count >= 9'(THR));
`ifdef WR_TAIL_FLUSH_EN
        m_tt = enable && tail_status && (count != 0) && (count < 9'(THR));
`else
        m_tt = 0;
`endif
        m_cnt = count;
        if (count >= 9'(FULL - 1)) m_ovf = 1;
        else if (!enable) m_ovf = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // Accept the pending request and complete it; caller has already drained count.
    task automatic finish_request();
        resp = 1'b1; tick(); resp = 1'b0;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({burst_req, tail_req, busy, overflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {burst_req, tail_req, busy, overflow});
        else n_pass++;
        n_total++;
        if (req_len !== '0) $display("FAIL reset_len: got %0d want 0", req_len);
        else n_pass++;
    endtask

    task automatic test_full_burst();
        enable = 1'b1; count = '0; tick();
        for (int c = 0; c < 128; c += 32) begin
            count = 9'(c); tick();
        end
        count = 9'd128; tick();
        n_total++;
        if (burst_req !== 1'b0) $display("FAIL burst_early: got %b want 0", burst_req);
        else n_pass++;
        tick();
        n_total++;
        if ({burst_req, busy} !== 2'b11) $display("FAIL burst_rise: got %b want 11", {burst_req, busy});
        else n_pass++;
        n_total++;
        if (req_len !== 9'd128) $display("FAIL burst_len: got %0d want 128", req_len);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (burst_req !== 1'b1) $display("FAIL burst_hold: got %b want 1", burst_req);
        else n_pass++;
        resp = 1'b1; tick(); resp = 1'b0;
        count = '0;
        n_total++;
        if ({burst_req, busy} !== 2'b01) $display("FAIL burst_resp: got %b want 01", {burst_req, busy});
        else n_pass++;
        repeat (9) tick();
        n_total++;
        if (req_len !== 9'd128) $display("FAIL burst_len_stable: got %0d want 128", req_len);
        else n_pass++;
        done = 1'b1; tick(); done = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL burst_fsh_busy: got %b want 1", busy);
        else n_pass++;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL burst_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_tail();
        bit seen;
        seen = 0;
        enable = 1'b1; count = 9'd37; tail_status = 1'b1;
`ifdef WR_TAIL_FLUSH_EN
        tick();
        n_total++;
        if (tail_req !== 1'b0) $display("FAIL tail_early: got %b want 0", tail_req);
        else n_pass++;
        tick();
        n_total++;
        if ({tail_req, burst_req, busy} !== 3'b101)
            $display("FAIL tail_rise: got %b want 101", {tail_req, burst_req, busy});
        else n_pass++;
        n_total++;
        if (req_len !== 9'd37) $display("FAIL tail_len: got %0d want 37", req_len);
        else n_pass++;
        count = '0; tail_status = 1'b0;
        finish_request();
`else
        repeat (100) begin
            tick();
            if (tail_req !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL tail_disabled: got activity %b want 0", seen);
        else n_pass++;
        count = '0; tail_status = 1'b0;
        tick(); tick();
`endif
    endtask

    task automatic test_priority();
        enable = 1'b1; count = 9'd200; tail_status = 1'b1;
        tick(); tick();
        n_total++;
        if ({burst_req, tail_req} !== 2'b10)
            $display("FAIL prio_req: got %b want 10", {burst_req, tail_req});
        else n_pass++;
        n_total++;
        if (req_len !== 9'd128) $display("FAIL prio_len: got %0d want 128", req_len);
        else n_pass++;
        count = '0; tail_status = 1'b0;
        finish_request();
    endtask

    task automatic test_enable_drop();
        bit seen;
        seen = 0;
        enable = 1'b1; count = 9'd200;
        tick(); tick();
        enable = 1'b0;
        repeat (4) tick();
        n_total++;
        if (burst_req !== 1'b1) $display("FAIL endrop_hold: got %b want 1", burst_req);
        else n_pass++;
        resp = 1'b1; tick(); resp = 1'b0;
        n_total++;
        if ({burst_req, busy} !== 2'b01) $display("FAIL endrop_resp: got %b want 01", {burst_req, busy});
        else n_pass++;
        done = 1'b1; tick(); done = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0) $display("FAIL endrop_idle: got %b want 0", busy);
        else n_pass++;
        repeat (20) begin
            tick();
            if (busy !== 1'b0 || burst_req !== 1'b0) seen = 1;
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL endrop_norequest: got activity %b want 0", seen);
        else n_pass++;
        count = '0; enable = 1'b1;
        tick();
    endtask

    task automatic test_stray_overflow();
        enable = 1'b1; count = '0;
        tick(); tick();
        resp = 1'b1; done = 1'b1; tick(); resp = 1'b0; done = 1'b0;
        tick();
        n_total++;
        if ({burst_req, busy} !== 2'b00) $display("FAIL stray_idle: got %b want 00", {burst_req, busy});
        else n_pass++;
        count = 9'd255; tick();
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow);
        else n_pass++;
        count = 9'd10; tick();
        n_total++;
        if ({overflow, burst_req} !== 2'b11) $display("FAIL ovf_hold: got %b want 11", {overflow, burst_req});
        else n_pass++;
        count = '0;
        finish_request();
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
        else n_pass++;
        enable = 1'b0; tick();
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
        else n_pass++;
        enable = 1'b1; tick();
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; count = 9'd150;
        tick(); tick();
        resp = 1'b1; tick(); resp = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({burst_req, tail_req, busy, overflow, req_len} !== 13'd0)
            $display("FAIL rstmid_outputs: got %b want 0", {burst_req, tail_req, busy, overflow, req_len});
        else n_pass++;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (burst_req !== 1'b0) $display("FAIL rstmid_trig: got %b want 0", burst_req);
        else n_pass++;
        tick();
        n_total++;
        if ({burst_req, req_len} !== {1'b1, 9'd128})
            $display("FAIL rstmid_reburst: got req=%b len=%0d want req=1 len=128", burst_req, req_len);
        else n_pass++;
        count = '0;
        finish_request();
    endtask

    task automatic test_random();
        int r;
        int fails;
        logic [12:0] exp_v;
        fails = 0;
        do_reset();
        for (int i = 0; i < 2000 && fails < 20; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 9);
            if (r < 5) count = 9'($urandom_range(0, 127));
            else if (r < 9) count = 9'($urandom_range(128, 254));
            else count = 9'($urandom_range(255, 300));
            tail_status = ($urandom_range(0, 1) == 1);
            resp = ($urandom_range(0, 3) == 0);
            done = ($urandom_range(0, 3) == 0);
            tick();
            exp_v = {m_req == 1, m_req == 2, (m_req != 0) || m_inflight || (m_cool > 0), m_ovf, m_len};
            n_total++;
            if ({burst_req, tail_req, busy, overflow, req_len} !== exp_v) begin
                fails++;
                $display("FAIL random_cycle%0d: got b/t/busy/ovf/len=%b want %b", i,
                         {burst_req, tail_req, busy, overflow, req_len}, exp_v);
            end else n_pass++;
        end
        resp = 1'b0; done = 1'b0; tail_status = 1'b0; count = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_burst();
        test_tail();
        test_priority();
        test_enable_drop();
        test_stray_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/write_fifo_status_ctrl.md
# write_fifo_status_ctrl

Write-path burst scheduler for the VDMA. It monitors the fill level of the video-input FIFO and asks the AXI write master to drain it to memory. A full burst of THRESHOLD beats is requested whenever enough data has accumulated. A shorter tail burst flushes the residue at frame end. It is the write-direction counterpart of the read-side FIFO status controller, and it drives the same `burst_req`/`tail_req`/`resp`/`done` handshake toward the AXI master.

## Interface

Parameters:
- THRESHOLD, 128: full-burst length in beats; also the fill level that triggers a full burst.
- FULL_LEN, 256: FIFO depth in words; used only for overflow detection.
- LSIZE, 9: width of `req_len`.

Ports:
- clock  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new requests; an in-flight request always completes.
- count  in  9  FIFO read-side word count, synchronous to `clock`.
- tail_status  in  1  last word of the current frame is in the FIFO; held until the FIFO is drained.
- burst_req  out  1  full-burst request, level.
- tail_req  out  1  tail-burst request, level.
- resp  in  1  one-cycle pulse: master has accepted the pending request.
- done  in  1  one-cycle pulse: accepted burst has completed on AXI.
- req_len  out  LSIZE  burst length for the pending request; stable from request until `done`.
- busy  out  1  high whenever the FSM is not in IDLE.
- overflow  out  1  sticky flag: FIFO observed at or above FULL_LEN-1.

## Operation

- Registered triggers, updated every cycle:
  - trig_burst = enable && (count >= THRESHOLD)
  - trig_tail = enable && tail_status && (count != 0) && (count < THRESHOLD)
  - cnt_q = count (snapshot)
- State machine (states IDLE, NEED_WR, WR_TAIL, WAIT_DONE, FSH):
  - IDLE: if trig_burst, go to NEED_WR. Else if trig_tail, go to WR_TAIL. Else stay. Burst has priority over tail.
  - NEED_WR: on resp, go to WAIT_DONE; otherwise hold.
  - WR_TAIL: on resp, go to WAIT_DONE; otherwise hold.
  - WAIT_DONE: on done, go to FSH; otherwise hold.
  - FSH: one cycle, then IDLE. This gives the FIFO count time to reflect the drained words before re-triggering.
  - Undefined state encodings go to IDLE.
- Outputs are registered from the next state:
  - burst_req = (nstate == NEED_WR)
  - tail_req = (nstate == WR_TAIL)
  - busy = (nstate != IDLE)
- req_len is loaded as follows and holds otherwise:
  - THRESHOLD when entering NEED_WR.
  - cnt_q[LSIZE-1:0] when entering WR_TAIL.
- overflow:
  - Set when count >= FULL_LEN-1.
  - Cleared only when enable is low.
  - Set has priority over clear.
- enable falling during NEED_WR, WR_TAIL or WAIT_DONE does not abort the request; the FSM completes to IDLE.
- resp arriving in IDLE, WAIT_DONE or FSH is ignored. done arriving outside WAIT_DONE is ignored.
- If resp and done arrive in the same cycle while in NEED_WR or WR_TAIL, only resp is acted on; the master must issue done later.

## Timing

- Reset values: burst_req, tail_req, busy, overflow all 0; req_len 0; state IDLE; triggers 0.
- Trigger latency: count reaches THRESHOLD at edge N → trig_burst high after edge N+1 → burst_req and busy high after edge N+2.
- Request lifetime: burst_req falls on the edge that samples resp high. WAIT_DONE spans the cycles until done. IDLE is re-entered two edges after done is sampled.
- Minimum spacing: two consecutive requests are at least 4 cycles apart (resp, done, FSH, IDLE).
- req_len is valid in the same cycle that burst_req/tail_req rises.
- Asynchronous reset mid-burst returns everything to reset values immediately. The master must also be reset.

## Configuration

- `WR_TAIL_FLUSH_EN` defined:
  - trig_tail, the WR_TAIL state and tail_req behave as described above.
- `WR_TAIL_FLUSH_EN` undefined:
  - trig_tail is constant 0 and WR_TAIL is unreachable.
  - tail_req is tied to 0.
  - Residual data below THRESHOLD waits in the FIFO until later frames push count to THRESHOLD.

## Test plan

- **Full burst.** Ramp count 0→128 with enable=1; resp 3 cycles after burst_req; done 10 cycles later. Required: burst_req high 2 cycles after count=128, req_len=128, busy falls 2 cycles after done.
- **Tail flush** (macro on). count=37, tail_status=1, enable=1. Required: tail_req high and req_len=37. Macro off: tail_req stays 0 for 100 cycles.
- **Priority.** count=200 with tail_status=1. Required: burst_req (not tail_req), req_len=128.
- **Enable drop mid-request.** Deassert enable while in NEED_WR. Required: burst_req held until resp; FSM completes; no new request while enable=0, even with count=200.
- **Stray handshakes and overflow.**
  - Pulse resp and done while in IDLE → no state change.
  - Drive count=255 → overflow=1, staying 1 while count falls; cleared 1 cycle after enable=0.
- **Reset mid-operation.** Assert rst_n=0 during WAIT_DONE. Required: all outputs 0 immediately; with count=150 after release, a new burst_req 2 cycles after the first trigger edge.
